writeback_stage: RTL and testbench

// Final pipeline stage, directly downstream of the memory stage. Consumes the memory-stage uop and does one of three

---
 rtl/writeback_stage.sv | 151 +++++++++++++++
 tb/tb_writeback_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - final pipeline stage: retire, replay nacked memory uops, or run the trap sequence
module writeback_stage #(
  parameter int XLEN    = 32,
  parameter int EX_W    = 4,
  parameter int FLAGS_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [4:0]         in_rd,
  input  logic [XLEN-1:0]    in_rd_val,
  input  logic               in_flags_valid,
  input  logic [FLAGS_W-1:0] in_flags,
  input  logic               in_ex_valid,
  input  logic [EX_W-1:0]    in_ex,
  input  logic               in_mem_nack,
  output logic               in_stall,
  input  logic [XLEN-1:0]    mtvec,
  output logic               rf_we,
  output logic [4:0]         rf_waddr,
  output logic [XLEN-1:0]    rf_wdata,
  output logic               flags_we,
  output logic [FLAGS_W-1:0] flags_wdata,
  output logic               csr_we,
  output logic               csr_sel,
  output logic [XLEN-1:0]    csr_wdata,
  output logic               flush,
  output logic               fetch_hold,
  output logic               redirect_valid,
  output logic [XLEN-1:0]    redirect_pc,
  output logic [63:0]        instret
);

  typedef enum logic [1:0] {IDLE, SAVE, CAUSE, REDIR} trapState_t;

  trapState_t         state, stateNext;
  logic               rValid, rFlagsValid, rExValid, rMemNack;
  logic [XLEN-1:0]    rPc, rRdVal, trapPc;
  logic [4:0]         rRd;
  logic [FLAGS_W-1:0] rFlags;
  logic [EX_W-1:0]    rEx, trapEx;
  logic [63:0]        instretQ;
  logic               takeTrap, doReplay, doRetire, drop, capture;

  assign takeTrap = rValid && (state == IDLE) && rExValid;
  assign doReplay = rValid && (state == IDLE) && !rExValid && rMemNack;
  assign doRetire = rValid && (state == IDLE) && !rExValid && !rMemNack;
  // A flush kills the younger uop arriving in the same cycle; traps also block intake until IDLE.
  assign drop     = flush || (state != IDLE);
  assign capture  = in_valid && !drop;
  assign in_stall = 1'b0;
  assign instret  = instretQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rValid      <= 1'b0;
      rPc         <= '0;
      rRd         <= '0;
      rRdVal      <= '0;
      rFlagsValid <= 1'b0;
      rFlags      <= '0;
      rExValid    <= 1'b0;
      rEx         <= '0;
      rMemNack    <= 1'b0;
    end else begin
      rValid <= capture;
      if (capture) begin
        rPc         <= in_pc;
        rRd         <= in_rd;
        rRdVal      <= in_rd_val;
        rFlagsValid <= in_flags_valid;
        rFlags      <= in_flags;
        rExValid    <= in_ex_valid;
        rEx         <= in_ex;
        rMemNack    <= in_mem_nack;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      trapPc   <= '0;
      trapEx   <= '0;
      instretQ <= '0;
    end else begin
      state <= stateNext;
      if (takeTrap) begin
        trapPc <= rPc;
        trapEx <= rEx;
      end
      if (doRetire) instretQ <= instretQ + 64'd1;
    end
  end

  always_comb begin
    stateNext      = state;
    rf_we          = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    flags_we       = 1'b0;
    flags_wdata    = '0;
    csr_we         = 1'b0;
    csr_sel        = 1'b0;
    csr_wdata      = '0;
    flush          = 1'b0;
    fetch_hold     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    unique case (state)
      IDLE: begin
        if (takeTrap) begin
          flush      = 1'b1;
          fetch_hold = 1'b1;
          stateNext  = SAVE;
        end else if (doReplay) begin
          flush          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = rPc;
        end else if (doRetire) begin
          rf_we       = (rRd != 5'd0);
          rf_waddr    = rRd;
          rf_wdata    = rRdVal;
          flags_we    = rFlagsValid;
          flags_wdata = rFlagsValid ? rFlags : '0;
        end
      end
      SAVE: begin
        csr_we     = 1'b1;
        csr_wdata  = trapPc;
        fetch_hold = 1'b1;
        stateNext  = CAUSE;
      end
      CAUSE: begin
        csr_we     = 1'b1;
        csr_sel    = 1'b1;
        csr_wdata  = {{(XLEN-EX_W){1'b0}}, trapEx};
        fetch_hold = 1'b1;
        stateNext  = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        redirect_pc    = mtvec;
        stateNext      = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - scoreboard bench for writeback_stage: directed cases plus randomized uop traffic
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [4:0]  in_rd = '0;
  logic [31:0] in_rd_val = '0;
  logic        in_flags_valid = 1'b0;
  logic [3:0]  in_flags = '0;
  logic        in_ex_valid = 1'b0;
  logic [3:0]  in_ex = '0;
  logic        in_mem_nack = 1'b0;
  logic        in_stall;
  logic [31:0] mtvec = '0;
  logic        rf_we, flags_we, csr_we, csr_sel, flush, fetch_hold, redirect_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, csr_wdata, redirect_pc;
  logic [3:0]  flags_wdata;
  logic [63:0] instret;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_rd(in_rd),
    .in_rd_val(in_rd_val), .in_flags_valid(in_flags_valid), .in_flags(in_flags),
    .in_ex_valid(in_ex_valid), .in_ex(in_ex), .in_mem_nack(in_mem_nack), .in_stall(in_stall),
    .mtvec(mtvec), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .flags_we(flags_we), .flags_wdata(flags_wdata), .csr_we(csr_we), .csr_sel(csr_sel),
    .csr_wdata(csr_wdata), .flush(flush), .fetch_hold(fetch_hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        rfWe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        flagsWe;
    logic [3:0]  flagsData;
    logic        csrWe;
    logic        csrSel;
    logic [31:0] csrData;
    logic        flush;
    logic        hold;
    logic        redirV;
    logic        useMtvec;
    logic [31:0] redirPc;
    logic        retire;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mtvecAt[1024];
  int          cyc = 0;
  int          busyUntil = 0;
  int          nChecks = 0;
  int          nFail = 0;
  logic [63:0] expInstret = '0;
  logic        monEn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nChecks++;
    if (act !== expv) begin
      nFail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  function automatic exp_t blank(input int c);
    exp_t e;
    e = '{default: 0};
    e.cyc = c;
    return e;
  endfunction

  // Reference model: what each accepted uop causes, and for how long the stage refuses new uops.
  task automatic model(input int t, input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val,
                       input logic fv, input logic [3:0] fl, input logic exv, input logic [3:0] ex,
                       input logic nack);
    exp_t e;
    if (exv) begin
      e = blank(t + 1); e.flush = 1; e.hold = 1; sbq.push_back(e);
      e = blank(t + 2); e.csrWe = 1; e.csrSel = 0; e.csrData = pc; e.hold = 1; sbq.push_back(e);
      e = blank(t + 3); e.csrWe = 1; e.csrSel = 1; e.csrData = {28'd0, ex}; e.hold = 1; sbq.push_back(e);
      e = blank(t + 4); e.redirV = 1; e.useMtvec = 1; sbq.push_back(e);
      busyUntil = t + 5;
    end else if (nack) begin
      e = blank(t + 1); e.flush = 1; e.redirV = 1; e.redirPc = pc; sbq.push_back(e);
      busyUntil = t + 2;
    end else begin
      e = blank(t + 1); e.rfWe = (rd != 0); e.waddr = rd; e.wdata = val;
      e.flagsWe = fv; e.flagsData = fl; e.retire = 1; sbq.push_back(e);
      busyUntil = t + 1;
    end
  endtask

  task automatic sendUop(input logic v, input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] val,
                         input logic fv, input logic [3:0] fl, input logic exv, input logic [3:0] ex,
                         input logic nack);
    in_valid = v; in_pc = pc; in_rd = rd; in_rd_val = val;
    in_flags_valid = fv; in_flags = fl; in_ex_valid = exv; in_ex = ex; in_mem_nack = nack;
    mtvec = $urandom;
    mtvecAt[cyc % 1024] = mtvec;
    if (v && rst_n && cyc >= busyUntil) model(cyc, pc, rd, val, fv, fl, exv, ex, nack);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sendUop(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chkQuiet(input string tag);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_flags_we"}, flags_we, 0);
    chk({tag, "_csr_we"}, csr_we, 0);
    chk({tag, "_flush"}, flush, 0);
    chk({tag, "_fetch_hold"}, fetch_hold, 0);
    chk({tag, "_redirect_valid"}, redirect_valid, 0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
    chk({tag, "_rf_wdata"}, rf_wdata, 0);
    chk({tag, "_csr_wdata"}, csr_wdata, 0);
    chk({tag, "_in_stall"}, in_stall, 0);
    chk({tag, "_instret"}, instret, 0);
  endtask

  always @(negedge clk) begin
    if (monEn) begin
      exp_t e;
      if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
        chk("stale_expectation", sbq[0].cyc, cyc);
        void'(sbq.pop_front());
      end
      if (sbq.size() > 0 && sbq[0].cyc == cyc) e = sbq.pop_front();
      else e = blank(cyc);
      chk("rf_we", rf_we, e.rfWe);
      if (e.rfWe) begin
        chk("rf_waddr", rf_waddr, e.waddr);
        chk("rf_wdata", rf_wdata, e.wdata);
      end
      chk("flags_we", flags_we, e.flagsWe);
      if (e.flagsWe) chk("flags_wdata", flags_wdata, e.flagsData);
      chk("csr_we", csr_we, e.csrWe);
      if (e.csrWe) begin
        chk("csr_sel", csr_sel, e.csrSel);
        chk("csr_wdata", csr_wdata, e.csrData);
      end
      chk("flush", flush, e.flush);
      chk("fetch_hold", fetch_hold, e.hold);
      chk("redirect_valid", redirect_valid, e.redirV);
      if (e.redirV) chk("redirect_pc", redirect_pc, e.useMtvec ? mtvecAt[cyc % 1024] : e.redirPc);
      chk("in_stall", in_stall, 0);
      chk("instret", instret, expInstret);
      if (e.retire) expInstret = expInstret + 64'd1;
    end
  end

  initial begin
    idle(3);
    chkQuiet("reset");
    rst_n = 1'b1;
    busyUntil = 0;
    monEn = 1'b1;
    idle(2);

    // Retire with flags, then three x0 writes back to back
    sendUop(1, 32'h10, 5, 32'hDEADBEEF, 1, 4'hA, 0, 0, 0);
    for (int i = 0; i < 3; i++) sendUop(1, 32'h14 + 4 * i, 0, $urandom, 0, 0, 0, 0, 0);
    idle(2);
    chk("instret_after_retires", instret, 64'd4);

    // Nack replay with a younger uop right behind it
    sendUop(1, 32'h100, 3, 32'h1, 0, 0, 0, 0, 1);
    sendUop(1, 32'h104, 4, 32'h2, 1, 4'h3, 0, 0, 0);
    idle(2);
    chk("instret_after_replay", instret, 64'd4);

    // Trap, then trap with nack also set, with traffic arriving during the sequence
    sendUop(1, 32'h200, 6, 32'h5, 0, 0, 1, 4'd4, 0);
    for (int i = 0; i < 5; i++) sendUop(1, 32'h300 + 4 * i, 7, $urandom, 1, 4'h1, 0, 0, 0);
    sendUop(1, 32'h400, 8, 32'h9, 0, 0, 1, 4'd7, 1);
    idle(6);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic v, exv, nack, fv;
      logic [4:0] rd;
      v    = ($urandom_range(0, 9) < 7);
      exv  = ($urandom_range(0, 99) < 12);
      nack = ($urandom_range(0, 99) < 15);
      fv   = $urandom_range(0, 1);
      rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      sendUop(v, $urandom, rd, $urandom, fv, 4'($urandom), exv, 4'($urandom), nack);
    end
    idle(6);

    // Reset in the middle of a trap, during CAUSE
    sendUop(1, 32'h500, 2, 32'h0, 0, 0, 1, 4'd9, 0);
    idle(2);
    monEn = 1'b0;
    rst_n = 1'b0;
    #1;
    chkQuiet("midtrap_reset");
    idle(2);
    rst_n = 1'b1;
    sbq.delete();
    busyUntil = 0;
    expInstret = '0;
    monEn = 1'b1;
    idle(5);
    sendUop(1, 32'h600, 9, 32'h77, 0, 0, 0, 0, 0);
    idle(2);
    chk("instret_after_reset", instret, 64'd1);

    // Counter wrap from all ones to zero
    monEn = 1'b0;
    force dut.instretQ = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instretQ;
    expInstret = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("instret_preset", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    monEn = 1'b1;
    sendUop(1, 32'h700, 1, 32'h1234, 0, 0, 0, 0, 0);
    idle(3);
    chk("instret_wrap", instret, 64'd0);

    idle(4);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
